// File: rtl/axis_width_downsizer.sv
// AXI-Stream width down-converter: one wide beat in, RATIO narrow beats out,
// LSB slice first, tlast on the final slice of a packet, plus a packet counter.
module axis_width_downsizer #(
    parameter int unsigned S_WIDTH   = 64,
    parameter int unsigned M_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_areset,
    input  logic [S_WIDTH-1:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [M_WIDTH-1:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    localparam int unsigned RATIO = S_WIDTH / M_WIDTH;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Reject widths that do not split into at least two whole slices
    generate
        if ((S_WIDTH % M_WIDTH) != 0 || RATIO < 2) begin : g_param_check
            $fatal(1, "axis_width_downsizer: S_WIDTH must be a multiple of M_WIDTH with ratio >= 2");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t             state;
    logic [S_WIDTH-1:0] buf_data;
    logic               buf_last;
    logic [IDX_W-1:0]   idx;

    logic buf_valid;
    logic last_slice;
    logic in_accept;
    logic out_accept;

    // Handshake decode; ready reopens on the final slice so reload has no bubble
    always_comb begin
        buf_valid     = (state == ST_SERVE);
        last_slice    = (idx == LAST_IDX);
        s_axis_tready = !buf_valid | (m_axis_tready & last_slice);
        in_accept     = s_axis_tvalid & s_axis_tready;
        out_accept    = buf_valid & m_axis_tready;
        m_axis_tvalid = buf_valid;
        m_axis_tlast  = buf_valid & buf_last & last_slice;
    end

    // Select the current narrow slice out of the buffered wide word
    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (idx == IDX_W'(i)) begin
                m_axis_tdata = buf_data[i*M_WIDTH +: M_WIDTH];
            end
        end
    end

    // Buffer/slice state machine and packet counter
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state     <= ST_EMPTY;
            buf_data  <= '0;
            buf_last  <= 1'b0;
            idx       <= '0;
            pkt_count <= '0;
        end else begin
            if (out_accept) begin
                if (last_slice) begin
                    idx   <= '0;
                    state <= ST_EMPTY;
                    if (buf_last) begin
                        pkt_count <= pkt_count + CNT_WIDTH'(1);
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            // A same-cycle load overrides the drain back to EMPTY
            if (in_accept) begin
                buf_data <= s_axis_tdata;
                buf_last <= s_axis_tlast;
                idx      <= '0;
                state    <= ST_SERVE;
            end
        end
    end

endmodule
